// File: rtl/cnnacc_pkg.sv
// cnnacc_pkg: shared BRAM32k geometry, int8 lane layout and the ofmap reader state encoding.
// relu_lanes is used by ofmap_reader only when OFMAP_READER_RELU_EN is defined.
package cnnacc_pkg;

  localparam int BRAM32K_ADDR_W = 12;
  localparam int BRAM32K_DATA_W = 64;
  localparam int LANE_W         = 8;
  localparam int LANES          = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } ofmap_state_e;

  // Clamp every signed int8 lane to zero when its sign bit is set.
  function automatic logic [LANES*LANE_W-1:0] relu_lanes(input logic [LANES*LANE_W-1:0] w);
    logic [LANES*LANE_W-1:0] r;
    r = w;
    for (int i = 0; i < LANES; i++) begin
      if (w[i*LANE_W + LANE_W - 1]) begin
        r[i*LANE_W +: LANE_W] = {LANE_W{1'b0}};
      end else begin
        r[i*LANE_W +: LANE_W] = w[i*LANE_W +: LANE_W];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ofmap_rd_fifo.sv
// ofmap_rd_fifo: synchronous FIFO whose head sits in a registered output stage.
// A push into an empty FIFO shows up on rdata_o/rvalid_o the following cycle (no bypass).
module ofmap_rd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rvalid_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    rc_q, rc_d;
  logic [WIDTH-1:0] out_q;
  logic             out_vld_q;
  logic             pop_s, out_free_s, ring_rd_s, ring_wr_s;

  // Route a push either straight into the empty output stage or into the ring behind it.
  always_comb begin
    pop_s      = pop_i && out_vld_q;
    out_free_s = !out_vld_q || pop_s;
    ring_rd_s  = out_free_s && (rc_q != {CW{1'b0}});
    ring_wr_s  = push_i && !(out_free_s && (rc_q == {CW{1'b0}}));
    rc_d       = rc_q + CW'(ring_wr_s) - CW'(ring_rd_s);
  end

  // Ring storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (ring_wr_s) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers, ring occupancy and the registered output stage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q    <= {PW{1'b0}};
      rptr_q    <= {PW{1'b0}};
      rc_q      <= {CW{1'b0}};
      out_q     <= {WIDTH{1'b0}};
      out_vld_q <= 1'b0;
    end else begin
      rc_q <= rc_d;
      if (ring_wr_s) wptr_q <= wptr_q + PW'(1);
      if (ring_rd_s) rptr_q <= rptr_q + PW'(1);
      if (out_free_s) begin
        if (ring_rd_s) begin
          out_q     <= mem_q[rptr_q];
          out_vld_q <= 1'b1;
        end else if (push_i) begin
          out_q     <= wdata_i;
          out_vld_q <= 1'b1;
        end else begin
          out_vld_q <= 1'b0;
        end
      end
    end
  end

  assign rdata_o  = out_q;
  assign rvalid_o = out_vld_q;
  assign count_o  = rc_q + CW'(out_vld_q);
  assign full_o   = (count_o == CW'(DEPTH));
  assign empty_o  = (count_o == {CW{1'b0}});

  ofmap_rd_fifo_chk u_chk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (push_i),
    .pop_i  (pop_s),
    .full_i (full_o)
  );

endmodule

// Overflow monitor: a push into a full FIFO is only legal together with a pop.
module ofmap_rd_fifo_chk (
  input logic clk_i,
  input logic rst_i,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_i && !pop_i))
    else $error("ofmap_rd_fifo: push into full FIFO");

endmodule

// File: rtl/ofmap_reader.sv
// ofmap_reader: drains output feature-map words from BRAM32k port A onto a valid/ready stream.
// Reads are credit-limited by buffer space; define OFMAP_READER_RELU_EN to zero negative int8 lanes.
module ofmap_reader
  import cnnacc_pkg::*;
#(
  parameter int ADDR_W     = BRAM32K_ADDR_W,
  parameter int DATA_W     = BRAM32K_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  input  logic              wr_busy,
  output logic [ADDR_W-1:0] addr_BRAM32k_1,
  input  logic [DATA_W-1:0] dout_BRAM32k_1,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  ofmap_state_e      state_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [ADDR_W:0]   cnt_q, issued_q, accepted_q;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic              busy_q, done_q;
  logic [CW-1:0]     inflight_s, fifo_count_s;
  logic              issue_s, push_s, accept_s, fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0] push_data_s;

  // Reads still travelling through the BRAM pipeline.
  always_comb begin
    inflight_s = {CW{1'b0}};
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_s = inflight_s + CW'(tag_q[i]);
    end
  end

  // Every outstanding read already owns a buffer slot, so a returning word can never be dropped.
  assign issue_s = (state_q == ISSUE) && !wr_busy && (issued_q != cnt_q) && !fifo_full_s
                && (({1'b0, inflight_s} + {1'b0, fifo_count_s}) < DEPTH_C);
  assign push_s   = tag_q[RD_LAT-1];
  assign accept_s = m_ready && !fifo_empty_s;

`ifdef OFMAP_READER_RELU_EN
  assign push_data_s = relu_lanes(dout_BRAM32k_1);
`else
  assign push_data_s = dout_BRAM32k_1;
`endif

  // Next tag vector: shift toward the push end and insert this cycle's issue.
  always_comb begin
    tag_d    = tag_q << 1'b1;
    tag_d[0] = issue_s;
  end

  // Read-tag shift register aligned with the BRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= {RD_LAT{1'b0}};
    end else begin
      tag_q <= tag_d;
    end
  end

  // Transfer FSM with its counters and registered address/busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= {ADDR_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      cnt_q      <= {(ADDR_W+1){1'b0}};
      issued_q   <= {(ADDR_W+1){1'b0}};
      accepted_q <= {(ADDR_W+1){1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            cnt_q      <= word_cnt;
            issued_q   <= {(ADDR_W+1){1'b0}};
            accepted_q <= {(ADDR_W+1){1'b0}};
            busy_q     <= 1'b1;
            if (word_cnt == {(ADDR_W+1){1'b0}}) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_s) begin
            addr_q   <= base_q + issued_q[ADDR_W-1:0];
            issued_q <= issued_q + ONE_C;
            if ((issued_q + ONE_C) == cnt_q) state_q <= DRAIN;
          end
          if (accept_s) accepted_q <= accepted_q + ONE_C;
        end
        DRAIN: begin
          if (accept_s) begin
            accepted_q <= accepted_q + ONE_C;
            if ((accepted_q + ONE_C) == cnt_q) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  ofmap_rd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .wdata_i (push_data_s),
    .pop_i   (accept_s),
    .rdata_o (m_data),
    .rvalid_o(m_valid),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign addr_BRAM32k_1 = addr_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ofmap_reader.sv
// tb_ofmap_reader: directed bench for ofmap_reader against a BRAM model whose word at addr i is {8{i[7:0]}}.
// Expected words pass through a reference ReLU when OFMAP_READER_RELU_EN is defined.
module tb_ofmap_reader;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_addr = 12'h000;
  logic [12:0] word_cnt = 13'd0;
  logic        wr_busy = 1'b0;
  logic [11:0] addr_BRAM32k_1;
  logic [63:0] dout_BRAM32k_1 = 64'h0;
  logic [63:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
  logic        done;

  logic [63:0] mem [4096];
  int          tests_run = 0;
  int          tests_failed = 0;

  ofmap_reader #(
    .ADDR_W(12), .DATA_W(64), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .wr_busy(wr_busy), .addr_BRAM32k_1(addr_BRAM32k_1), .dout_BRAM32k_1(dout_BRAM32k_1),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // BRAM model: the address register counts as the first latency cycle, this stage as the second.
  always @(posedge clk) dout_BRAM32k_1 <= mem[addr_BRAM32k_1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input logic [11:0] a);
    logic [63:0] w;
    w = mem[a];
`ifdef OFMAP_READER_RELU_EN
    for (int l = 0; l < 8; l++) if (w[l*8+7]) w[l*8 +: 8] = 8'h00;
`endif
    return w;
  endfunction

  // One transfer. rmode 0: m_ready always 1; rmode 1: m_ready cycles 1,0,0,1.
  task automatic run_xfer(input string name, input logic [11:0] base, input logic [12:0] cnt,
                          input int rmode, input int stall_at, input int ign_at, input bit chk_lat,
                          output logic [63:0] first_word);
    int c, nacc, niss, budget, first_v, last_acc, done_cnt, done_cyc, max_out;
    int data_err, addr_err, hold_err, stall_err, busy_err;
    logic [11:0] last_addr;
    logic [63:0] prev_data;
    bit prev_wait, prev_wb;
    c = 0; nacc = 0; niss = 0; first_v = -1; last_acc = 0; done_cnt = 0; done_cyc = -1;
    max_out = 0; data_err = 0; addr_err = 0; hold_err = 0; stall_err = 0; busy_err = 0;
    prev_wait = 1'b0; prev_wb = 1'b0; prev_data = 64'h0; first_word = 64'h0;
    budget = int'(cnt) * 4 + 40;
    @(negedge clk);
    last_addr = addr_BRAM32k_1;
    start = 1'b1; base_addr = base; word_cnt = cnt; m_ready = 1'b1; wr_busy = 1'b0;
    while (done_cnt == 0 && c < budget) begin
      @(negedge clk);
      c++;
      start = (c == ign_at);
      if (c == ign_at) begin
        base_addr = 12'h700;
        word_cnt  = 13'd3;
      end
      m_ready = (rmode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      wr_busy = (stall_at >= 0) && (c >= stall_at) && (c < stall_at + 5);
      if (!busy) busy_err++;
      if (prev_wait && (!m_valid || m_data != prev_data)) hold_err++;
      if (addr_BRAM32k_1 != last_addr || (c == 2 && niss == 0 && cnt != 13'd0)) begin
        if (prev_wb) stall_err++;
        if (addr_BRAM32k_1 != 12'(base + niss[11:0])) addr_err++;
        niss++;
        last_addr = addr_BRAM32k_1;
      end
      if (niss - nacc > max_out) max_out = niss - nacc;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (m_valid) begin
        if (first_v < 0) first_v = c;
        if (m_ready) begin
          if (m_data != exp_word(12'(base + nacc[11:0]))) data_err++;
          if (nacc == 0) first_word = m_data;
          nacc++;
          last_acc = c;
        end
      end
      prev_wait = m_valid && !m_ready;
      prev_data = m_data;
      prev_wb   = wr_busy;
    end
    start = 1'b0; wr_busy = 1'b0; m_ready = 1'b1;
    check_eq({name, " done seen"}, 64'(done_cnt), 64'd1);
    check_eq({name, " done timing"}, 64'(done_cyc), 64'(last_acc + 1));
    check_eq({name, " words"}, 64'(nacc), 64'(cnt));
    check_eq({name, " issues"}, 64'(niss), 64'(cnt));
    check_eq({name, " data"}, 64'(data_err), 64'd0);
    check_eq({name, " addr seq"}, 64'(addr_err), 64'd0);
    check_eq({name, " stall hold"}, 64'(hold_err), 64'd0);
    check_eq({name, " wr_busy addr"}, 64'(stall_err), 64'd0);
    check_eq({name, " busy"}, 64'(busy_err), 64'd0);
    check_eq({name, " outstanding"}, 64'(max_out <= FIFO_DEPTH), 64'd1);
    if (chk_lat) check_eq({name, " first valid"}, 64'(first_v), 64'(RD_LAT + 2));
    @(negedge clk);
    check_eq({name, " done after"}, 64'(done), 64'd0);
    check_eq({name, " busy after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] fw;
    bit seen_done, seen_valid;
    for (int i = 0; i < 4096; i++) mem[i] = {8{i[7:0]}};
    mem[12'h100] = 64'h80FF017F00FE0102;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset addr", 64'(addr_BRAM32k_1), 64'h0);
    check_eq("reset m_valid", 64'(m_valid), 64'h0);
    check_eq("reset m_data", m_data, 64'h0);
    check_eq("reset busy", 64'(busy), 64'h0);
    check_eq("reset done", 64'(done), 64'h0);
    rst = 1'b0;

    run_xfer("full", 12'h010, 13'd8, 0, -1, -1, 1'b1, fw);
    check_eq("full first word", fw, 64'h1010101010101010);
    run_xfer("bp", 12'h030, 13'd16, 1, -1, 6, 1'b0, fw);
    run_xfer("wrstall", 12'h050, 13'd16, 0, 6, -1, 1'b0, fw);
    run_xfer("wrap", 12'hFFE, 13'd4, 0, -1, -1, 1'b0, fw);
    check_eq("wrap last addr", 64'(addr_BRAM32k_1), 64'h001);
    run_xfer("cnt0", 12'h123, 13'd0, 0, -1, -1, 1'b0, fw);
    run_xfer("relu", 12'h100, 13'd1, 0, -1, -1, 1'b0, fw);
`ifdef OFMAP_READER_RELU_EN
    check_eq("relu word", fw, 64'h0000017F00000102);
`else
    check_eq("relu word", fw, 64'h80FF017F00FE0102);
`endif
    run_xfer("cnt4096", 12'h000, 13'd4096, 0, -1, -1, 1'b0, fw);

    // Abandon a transfer in DRAIN with the stream stalled.
    @(negedge clk);
    start = 1'b1; base_addr = 12'h040; word_cnt = 13'd4; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre-rst m_valid", 64'(m_valid), 64'h1);
    check_eq("pre-rst busy", 64'(busy), 64'h1);
    rst = 1'b1;
    #1;
    check_eq("rst async m_valid", 64'(m_valid), 64'h0);
    check_eq("rst async busy", 64'(busy), 64'h0);
    check_eq("rst async m_data", m_data, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    seen_done = 1'b0; seen_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen_done  = seen_done | done;
      seen_valid = seen_valid | m_valid;
    end
    check_eq("post-rst done", 64'(seen_done), 64'h0);
    check_eq("post-rst m_valid", 64'(seen_valid), 64'h0);
    run_xfer("fresh", 12'h020, 13'd5, 0, -1, -1, 1'b1, fw);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ofmap_reader.md
Name: ofmap_reader

Overview:
- Drains conv-layer output feature-map words from BRAM32k through read port A (12-bit address, 64-bit data, fixed read latency).
- Streams the words downstream over a valid/ready interface, for pooling, the next layer's input BRAM, or host readback.
- Sits beside pe1, at the read end of the PE-to-BRAM32k write path.
- Uses credit-based issue so that downstream backpressure never drops a BRAM word.

Parameters:
- ADDR_W, 12, BRAM32k address width
- DATA_W, 64, BRAM32k word width (8 lanes x int8)
- RD_LAT, 2, BRAM32k read latency in cycles, from address to dout valid (legal range 1..3)
- FIFO_DEPTH, 4, output buffer depth in words (power of 2, must be > RD_LAT)

Ports:
- clk  in  1  system clock (clk_wiz_0 clk_out1)
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that launches a transfer; accepted only in IDLE
- base_addr  in  ADDR_W  first word address, sampled on accepted start
- word_cnt  in  ADDR_W+1  number of words to read (0..4096), sampled on accepted start
- wr_busy  in  1  BRAM32k write enable from the PE; while high, no new read is issued
- addr_BRAM32k_1  out  ADDR_W  BRAM32k port-A read address
- dout_BRAM32k_1  in  DATA_W  BRAM32k port-A read data
- m_data  out  DATA_W  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, rst=1): state IDLE. addr_BRAM32k_1=0, m_valid=0, m_data=0, busy=0, done=0. FIFO is emptied and the in-flight pipeline is cleared.
- Reset mid-transfer: the transfer is abandoned and no done pulse is produced. After release, the next start begins a fresh transfer.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE -> ISSUE on start with word_cnt>0.
  - IDLE -> FIN on start with word_cnt=0.
  - ISSUE -> DRAIN when the issued count equals word_cnt.
  - DRAIN -> FIN when the accepted count equals word_cnt.
  - FIN -> IDLE after one cycle; done=1 during FIN only.
- busy=1 in ISSUE, DRAIN and FIN.
- start outside IDLE is ignored.
- Issue rule: one read per cycle in ISSUE when wr_busy=0 and (inflight + fifo_count) < FIFO_DEPTH.
  - Each issued read drives addr_BRAM32k_1 = base_addr + issued_count, modulo 2^ADDR_W (wraps 4095 -> 0).
  - Otherwise addr_BRAM32k_1 holds its last value.
- A shift register of length RD_LAT tags issued reads. When a tag emerges, dout_BRAM32k_1 is pushed into the FIFO in the same cycle.
- Data reaches the FIFO head RD_LAT cycles after issue. m_valid rises the following cycle (FIFO registered output).
- Minimum start-to-first-m_valid latency: RD_LAT+2 cycles.
- Handshake: a word transfers when m_valid && m_ready.
  - m_data and m_valid stay stable while m_valid && !m_ready.
  - m_valid never drops without a transfer.
- Overflow is impossible by construction. Any push to a full FIFO is a design error and is flagged by an assertion.
- Push and pop in the same cycle are allowed at every occupancy, including full (count unchanged) and empty (bypass is not permitted; the word appears on the next cycle).
- Sustained throughput is 1 word/cycle when m_ready=1 and wr_busy=0.
- Counters: issued and accepted counts are ADDR_W+1 bits wide, so word_cnt=4096 is representable.

Optional Feature:
- Macro: OFMAP_READER_RELU_EN.
- Defined: each of the 8 signed int8 lanes of a FIFO-pushed word is clamped to 0 when negative, before the push. This adds no latency.
- Undefined: words pass unmodified.

Decomposition:
- Package cnnacc_pkg holds:
  - BRAM32K_ADDR_W=12 and BRAM32K_DATA_W=64
  - LANE_W=8 and LANES=8
  - the FSM state enum (IDLE/ISSUE/DRAIN/FIN)
- Sub-module ofmap_rd_fifo: synchronous FIFO with registered output, parameterised width and depth, exposing count, full and empty, with async active-high rst.

Test Plan:
- Full-speed read: preload BRAM words with addr i -> data {8{i[7:0]}}; start with base=0x010, cnt=8 and m_ready=1. Expect data for 0x010..0x017 in order, m_valid first high at cycle RD_LAT+2, done pulsing once the cycle after the 8th accept.
- Backpressure: cnt=16 with m_ready toggling 1,0,0,1. Expect all 16 words in order with no loss or duplication, m_data stable during stalls, and at most FIFO_DEPTH outstanding reads.
- Writer stall: pulse wr_busy for 5 cycles mid-transfer. Expect no address change during those cycles and a correct, complete sequence afterwards.
- Wrap and size edges:
  - base=0xFFE, cnt=4: expect addresses FFE, FFF, 000, 001.
  - cnt=0: expect done 1 cycle after start and no m_valid.
  - cnt=4096: expect 4096 words.
- Reset and ignored start: assert rst during DRAIN. Expect m_valid=0 and busy=0 immediately (async), and no done. A start while busy is ignored.
- ReLU macro: word 0x80FF017F00FE0102. With OFMAP_READER_RELU_EN defined, expect 0x0000017F00000102; undefined, expect it unchanged.
